// File: rtl/jtag_dtm_v2.sv
// RISC-V Debug 0.13 DTM: JTAG DR side (DTMCS/DMI) to a held req/ack Debug Module Interface.
// Optional DTM_DMI_TIMEOUT_EN: abandons a request after TIMEOUT tck cycles without dmi_ack.
module jtag_dtm_v2 #(
    parameter int unsigned ABITS       = 7,
    parameter int unsigned IDLE_CYCLES = 1,
    parameter logic [4:0]  IR_DTMCS    = 5'h10,
    parameter logic [4:0]  IR_DMI      = 5'h11,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic             tck,
    input  logic             trst,
    input  logic [4:0]       ir_value,
    input  logic             dr_capture,
    input  logic             dr_shift,
    input  logic             dr_update,
    input  logic             tdi,
    output logic             tdo,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    output logic [1:0]       dmi_op,
    output logic             dmi_req,
    input  logic [31:0]      dmi_rdata,
    input  logic [1:0]       dmi_resp,
    input  logic             dmi_ack,
    output logic             dmi_busy
);

    localparam int unsigned DRW = ABITS + 34;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [DRW-1:0] shreg;
    logic [1:0]     sticky;
    logic [31:0]    rdata_q;

    logic        sel_dtmcs, sel_dmi;
    logic [1:0]  op_cap;
    logic [31:0] dtmcs_cap;
    logic        upd_issue, hard_rst, dmi_rst, ack_take, cap_busy, tmo_fire;

    assign sel_dtmcs = (ir_value == IR_DTMCS);
    assign sel_dmi   = (ir_value == IR_DMI);
    assign dmi_req   = (state_q == ST_WAIT);
    assign dmi_busy  = (state_q == ST_WAIT);

    assign op_cap    = dmi_busy ? 2'd3 : sticky;
    assign dtmcs_cap = {14'h0, 2'b00, 1'b0, 3'(IDLE_CYCLES), sticky, 6'(ABITS), 4'd1};

    // ST_ISSUE also blocks a new issue: the one-cycle gap before dmi_req rises.
    assign upd_issue = dr_update && sel_dmi && (shreg[1:0] == 2'd1 || shreg[1:0] == 2'd2)
                       && (sticky == 2'd0) && (state_q == ST_IDLE);
    assign hard_rst  = dr_update && sel_dtmcs && shreg[17];
    assign dmi_rst   = dr_update && sel_dtmcs && shreg[16];
    assign ack_take  = dmi_ack && (state_q == ST_WAIT) && !hard_rst;
    assign cap_busy  = dr_capture && sel_dmi && (state_q == ST_WAIT);

`ifdef DTM_DMI_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_fire = (state_q == ST_WAIT) && !dmi_ack && !hard_rst
                      && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            tmo_cnt <= '0;
        end else if (state_q != ST_WAIT || ack_take || hard_rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_fire       = 1'b0;
`endif

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (upd_issue) state_d = ST_ISSUE;
            ST_ISSUE: state_d = hard_rst ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (hard_rst || ack_take || tmo_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            shreg     <= '0;
            sticky    <= '0;
            rdata_q   <= '0;
            dmi_addr  <= '0;
            dmi_wdata <= '0;
            dmi_op    <= '0;
        end else begin
            if (dr_capture) begin
                if (sel_dtmcs) begin
                    shreg <= DRW'(dtmcs_cap);
                end else if (sel_dmi) begin
                    shreg <= {{ABITS{1'b0}}, rdata_q, op_cap};
                end
            end else if (dr_shift) begin
                if (sel_dmi) begin
                    shreg <= {tdi, shreg[DRW-1:1]};
                end else if (sel_dtmcs) begin
                    shreg <= {{(DRW-32){1'b0}}, tdi, shreg[31:1]};
                end
            end

            if (upd_issue) begin
                dmi_addr  <= shreg[DRW-1:34];
                dmi_wdata <= shreg[33:2];
                dmi_op    <= shreg[1:0];
            end

            if (ack_take) begin
                rdata_q <= dmi_rdata;
            end

            // Later assignments take priority: capture-busy beats a same-edge ack error,
            // and any reset of the sticky field beats both.
            if (ack_take && dmi_resp != 2'd0 && sticky == 2'd0) sticky <= dmi_resp;
            if (tmo_fire && sticky == 2'd0) sticky <= 2'd2;
            if (cap_busy && sticky == 2'd0) sticky <= 2'd3;
            if (dmi_rst || hard_rst) sticky <= '0;
        end
    end

    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo <= 1'b0;
        end else begin
            tdo <= (sel_dtmcs || sel_dmi) ? shreg[0] : 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_dtm_v2.sv
// Scoreboard bench for jtag_dtm_v2: drives TAP DR states and plays the Debug Module side.
module tb_jtag_dtm_v2;

    logic        tck, trst;
    logic [4:0]  ir_value;
    logic        dr_capture, dr_shift, dr_update, tdi, tdo;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata, dmi_rdata;
    logic [1:0]  dmi_op, dmi_resp;
    logic        dmi_req, dmi_ack, dmi_busy;

    jtag_dtm_v2 #(
        .ABITS(7), .IDLE_CYCLES(1), .IR_DTMCS(5'h10), .IR_DMI(5'h11), .TIMEOUT(8)
    ) dut (
        .tck(tck), .trst(trst), .ir_value(ir_value), .dr_capture(dr_capture),
        .dr_shift(dr_shift), .dr_update(dr_update), .tdi(tdi), .tdo(tdo),
        .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_op(dmi_op), .dmi_req(dmi_req),
        .dmi_rdata(dmi_rdata), .dmi_resp(dmi_resp), .dmi_ack(dmi_ack), .dmi_busy(dmi_busy)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } req_t;

    req_t        req_q[$];
    logic [33:0] cap_q[$];
    logic [31:0] last_rdata;
    int unsigned passed, total;

    // Called at negedge+1; returns at negedge+1 after the Update-DR posedge.
    task automatic scan(input logic [4:0] ir, input int unsigned width, input logic [63:0] din,
                        input bit ack_cap, input bit ack_upd, output logic [63:0] dout);
        dout = '0;
        ir_value = ir;
        dr_capture = 1'b1;
        if (ack_cap) dmi_ack = 1'b1;
        @(negedge tck); #1;
        dr_capture = 1'b0;
        dmi_ack = 1'b0;
        dr_shift = 1'b1;
        for (int unsigned i = 0; i < width; i++) begin
            dout[i] = tdo;
            tdi = din[i];
            @(negedge tck); #1;
        end
        dr_shift = 1'b0;
        dr_update = 1'b1;
        if (ack_upd) dmi_ack = 1'b1;
        @(negedge tck); #1;
        dr_update = 1'b0;
        dmi_ack = 1'b0;
    endtask

    task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                            input bit ack_cap, input bit ack_upd, output logic [33:0] cap);
        logic [63:0] dout;
        scan(5'h11, 41, 64'({a, d, op}), ack_cap, ack_upd, dout);
        cap = dout[33:0];
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dmi_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge tck); #1;
        end
    endtask

    task automatic cycle_ack(input logic [31:0] rd, input logic [1:0] resp);
        dmi_ack = 1'b1;
        dmi_rdata = rd;
        dmi_resp = resp;
        @(negedge tck); #1;
        dmi_ack = 1'b0;
        dmi_resp = 2'd0;
    endtask

    task automatic test_reset();
        trst = 1'b1;
        ir_value = 5'h00; dr_capture = 0; dr_shift = 0; dr_update = 0; tdi = 0;
        dmi_rdata = '0; dmi_resp = '0; dmi_ack = 0;
        last_rdata = '0;
        repeat (2) @(negedge tck);
        #1;
        total++;
        if ({tdo, dmi_addr, dmi_wdata, dmi_op, dmi_req, dmi_busy} !== '0)
            $display("FAIL reset_outputs: got %h, expected 0",
                     {tdo, dmi_addr, dmi_wdata, dmi_op, dmi_req, dmi_busy});
        else passed++;
        trst = 1'b0;
        @(negedge tck); #1;
        total++;
        if ({dmi_req, dmi_busy} !== 2'b00)
            $display("FAIL reset_release: got %b, expected 00", {dmi_req, dmi_busy});
        else passed++;
    endtask

    task automatic test_dtmcs();
        logic [63:0] d;
        scan(5'h10, 32, '0, 0, 0, d);
        total++;
        if (d[31:0] !== 32'h0000_1071) $display("FAIL dtmcs_capture: got %h, expected 00001071", d[31:0]);
        else passed++;
    endtask

    task automatic test_write();
        logic [33:0] cap, exp_cap;
        req_t        exp;
        bit          ok;
        int unsigned hi;
        req_q.push_back('{addr: 7'h10, data: 32'h8000_0001, op: 2'd2});
        dmi_scan(7'h10, 32'h8000_0001, 2'd2, 0, 0, cap);
        total++;
        if (dmi_req !== 1'b0) $display("FAIL write_latency: got req=%b, expected 0", dmi_req);
        else passed++;
        wait_req(ok);
        total++;
        if (!ok) $display("FAIL write_req_timeout: got req=%b, expected 1", dmi_req);
        else passed++;
        exp = req_q.pop_front();
        total++;
        if ({dmi_addr, dmi_wdata, dmi_op, dmi_busy} !== {exp, 1'b1})
            $display("FAIL write_issue: got %h, expected %h", {dmi_addr, dmi_wdata, dmi_op, dmi_busy}, {exp, 1'b1});
        else passed++;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            if (dmi_req === 1'b1) hi++;
            if (k == 3) begin dmi_ack = 1'b1; dmi_rdata = 32'h0000_1234; dmi_resp = 2'd0; end
            @(negedge tck); #1;
        end
        dmi_ack = 1'b0;
        last_rdata = 32'h0000_1234;
        total++;
        if (hi != 4 || dmi_req !== 1'b0)
            $display("FAIL write_req_width: got %0d cycles (req now %b), expected 4 (req 0)", hi, dmi_req);
        else passed++;
        cap_q.push_back({last_rdata, 2'd0});
        dmi_scan('0, '0, 2'd0, 0, 0, cap);
        exp_cap = cap_q.pop_front();
        total++;
        if (cap !== exp_cap) $display("FAIL write_capture: got %h, expected %h", cap, exp_cap);
        else passed++;
    endtask

    task automatic test_read();
        logic [33:0] cap, exp_cap;
        req_t        exp;
        bit          ok;
        req_q.push_back('{addr: 7'h11, data: 32'h0, op: 2'd1});
        dmi_scan(7'h11, 32'h0, 2'd1, 0, 0, cap);
        wait_req(ok);
        exp = req_q.pop_front();
        total++;
        if (!ok || {dmi_addr, dmi_wdata, dmi_op} !== exp)
            $display("FAIL read_issue: got %h (req %b), expected %h", {dmi_addr, dmi_wdata, dmi_op}, dmi_req, exp);
        else passed++;
        cycle_ack(32'hDEAD_BEEF, 2'd0);
        last_rdata = 32'hDEAD_BEEF;
        cap_q.push_back({last_rdata, 2'd0});
        dmi_scan('0, '0, 2'd0, 0, 0, cap);
        exp_cap = cap_q.pop_front();
        total++;
        if (cap !== exp_cap) $display("FAIL read_capture: got %h, expected %h", cap, exp_cap);
        else passed++;
    endtask

    task automatic test_busy();
        logic [33:0] cap, exp_cap;
        logic [63:0] d;
        req_t        exp;
        bit          ok;
        req_q.push_back('{addr: 7'h05, data: 32'h0, op: 2'd1});
        dmi_scan(7'h05, 32'h0, 2'd1, 0, 0, cap);
        wait_req(ok);
        exp = req_q.pop_front();
        total++;
        if (!ok || {dmi_addr, dmi_wdata, dmi_op} !== exp)
            $display("FAIL busy_issue: got %h (req %b), expected %h", {dmi_addr, dmi_wdata, dmi_op}, dmi_req, exp);
        else passed++;
        cap_q.push_back({last_rdata, 2'd3});
        dmi_scan(7'h06, 32'h0, 2'd1, 0, 0, cap);
        exp_cap = cap_q.pop_front();
        total++;
        if (cap !== exp_cap) $display("FAIL busy_capture: got %h, expected %h", cap, exp_cap);
        else passed++;
        total++;
        if (dmi_addr !== 7'h05 || dmi_req !== 1'b1)
            $display("FAIL busy_update_ignored: got addr %h req %b, expected addr 05 req 1", dmi_addr, dmi_req);
        else passed++;
        scan(5'h10, 32, 64'h0001_0000, 0, 0, d);
        total++;
        if (d[31:0] !== 32'h0000_1C71) $display("FAIL busy_sticky3: got %h, expected 00001c71", d[31:0]);
        else passed++;
        scan(5'h10, 32, '0, 0, 0, d);
        total++;
        if (d[31:0] !== 32'h0000_1071) $display("FAIL dmireset_clear: got %h, expected 00001071", d[31:0]);
        else passed++;
        cycle_ack(32'hA5A5_0001, 2'd0);
        last_rdata = 32'hA5A5_0001;
        total++;
        if (dmi_busy !== 1'b0) $display("FAIL busy_ack_done: got busy %b, expected 0", dmi_busy);
        else passed++;
    endtask

    task automatic test_sticky();
        logic [33:0] cap, exp_cap;
        logic [63:0] d;
        req_t        exp;
        bit          ok;
        req_q.push_back('{addr: 7'h20, data: 32'h1, op: 2'd2});
        dmi_scan(7'h20, 32'h1, 2'd2, 0, 0, cap);
        wait_req(ok);
        exp = req_q.pop_front();
        total++;
        if (!ok || {dmi_addr, dmi_wdata, dmi_op} !== exp)
            $display("FAIL sticky_issue: got %h (req %b), expected %h", {dmi_addr, dmi_wdata, dmi_op}, dmi_req, exp);
        else passed++;
        cycle_ack(32'h0BAD_0002, 2'd2);
        last_rdata = 32'h0BAD_0002;
        dmi_scan(7'h21, 32'h0, 2'd1, 0, 0, cap);
        repeat (3) @(negedge tck);
        #1;
        total++;
        if (dmi_req !== 1'b0) $display("FAIL sticky_blocks_issue: got req %b, expected 0", dmi_req);
        else passed++;
        cycle_ack(32'h0BAD_0003, 2'd3);
        scan(5'h10, 32, 64'h0001_0000, 0, 0, d);
        total++;
        if (d[31:0] !== 32'h0000_1871) $display("FAIL sticky_first_wins: got %h, expected 00001871", d[31:0]);
        else passed++;
        cap_q.push_back({last_rdata, 2'd0});
        dmi_scan('0, '0, 2'd0, 0, 0, cap);
        exp_cap = cap_q.pop_front();
        total++;
        if (cap !== exp_cap) $display("FAIL sticky_idle_ack_ignored: got %h, expected %h", cap, exp_cap);
        else passed++;
    endtask

    task automatic test_same_edge_capture();
        logic [33:0] cap, exp_cap;
        logic [63:0] d;
        bit          ok;
        req_q.push_back('{addr: 7'h22, data: 32'h0, op: 2'd1});
        dmi_scan(7'h22, 32'h0, 2'd1, 0, 0, cap);
        wait_req(ok);
        void'(req_q.pop_front());
        total++;
        if (!ok || dmi_addr !== 7'h22) $display("FAIL edge_issue: got addr %h req %b, expected 22 1", dmi_addr, dmi_req);
        else passed++;
        dmi_rdata = 32'hCAFE_F00D;
        dmi_resp = 2'd2;
        cap_q.push_back({last_rdata, 2'd3});
        dmi_scan('0, '0, 2'd0, 1, 0, cap);
        last_rdata = 32'hCAFE_F00D;
        exp_cap = cap_q.pop_front();
        total++;
        if (cap !== exp_cap || dmi_req !== 1'b0)
            $display("FAIL edge_ack_capture: got %h req %b, expected %h req 0", cap, dmi_req, exp_cap);
        else passed++;
        dmi_resp = 2'd0;
        scan(5'h10, 32, 64'h0001_0000, 0, 0, d);
        total++;
        if (d[31:0] !== 32'h0000_1C71) $display("FAIL edge_sticky3: got %h, expected 00001c71", d[31:0]);
        else passed++;
    endtask

    task automatic test_hardreset();
        logic [33:0] cap, exp_cap;
        logic [63:0] d;
        bit          ok;
        req_q.push_back('{addr: 7'h30, data: 32'h0, op: 2'd1});
        dmi_scan(7'h30, 32'h0, 2'd1, 0, 0, cap);
        wait_req(ok);
        void'(req_q.pop_front());
        total++;
        if (!ok || dmi_addr !== 7'h30) $display("FAIL hard_issue: got addr %h req %b, expected 30 1", dmi_addr, dmi_req);
        else passed++;
        dmi_rdata = 32'h5555_5555;
        scan(5'h10, 32, 64'h0002_0000, 0, 1, d);
        total++;
        if ({dmi_req, dmi_busy} !== 2'b00) $display("FAIL hard_abandon: got req/busy %b, expected 00", {dmi_req, dmi_busy});
        else passed++;
        cycle_ack(32'h6666_6666, 2'd2);
        cap_q.push_back({last_rdata, 2'd0});
        dmi_scan('0, '0, 2'd0, 0, 0, cap);
        exp_cap = cap_q.pop_front();
        total++;
        if (cap !== exp_cap) $display("FAIL hard_late_ack: got %h, expected %h", cap, exp_cap);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [33:0] cap, exp_cap;
        logic [31:0] rd;
        req_t        exp, nxt;
        bit          ok;
        for (int n = 0; n < 4; n++) begin
            nxt.addr = 7'($urandom);
            nxt.data = $urandom;
            nxt.op = 2'd2;
            req_q.push_back(nxt);
            cap_q.push_back({last_rdata, 2'd0});
            dmi_scan(nxt.addr, nxt.data, nxt.op, 0, 0, cap);
            exp_cap = cap_q.pop_front();
            total++;
            if (cap !== exp_cap) $display("FAIL b2b_capture: got %h, expected %h", cap, exp_cap);
            else passed++;
            wait_req(ok);
            exp = req_q.pop_front();
            total++;
            if (!ok || {dmi_addr, dmi_wdata, dmi_op} !== exp)
                $display("FAIL b2b_issue: got %h (req %b), expected %h", {dmi_addr, dmi_wdata, dmi_op}, dmi_req, exp);
            else passed++;
            rd = $urandom;
            cycle_ack(rd, 2'd0);
            last_rdata = rd;
        end
    endtask

    task automatic test_trst();
        logic [33:0] cap, exp_cap;
        logic [63:0] d;
        bit          ok;
        req_q.push_back('{addr: 7'h44, data: 32'h0, op: 2'd1});
        dmi_scan(7'h44, 32'h0, 2'd1, 0, 0, cap);
        wait_req(ok);
        void'(req_q.pop_front());
        @(negedge tck); #2;
        trst = 1'b1;
        #1;
        total++;
        if (!ok || {tdo, dmi_addr, dmi_wdata, dmi_op, dmi_req, dmi_busy} !== '0)
            $display("FAIL trst_async: got %h (req seen %b), expected 0",
                     {tdo, dmi_addr, dmi_wdata, dmi_op, dmi_req, dmi_busy}, ok);
        else passed++;
        @(negedge tck); #1;
        trst = 1'b0;
        last_rdata = '0;
        scan(5'h10, 32, '0, 0, 0, d);
        total++;
        if (d[31:0] !== 32'h0000_1071) $display("FAIL trst_dtmcs: got %h, expected 00001071", d[31:0]);
        else passed++;
        cap_q.push_back({last_rdata, 2'd0});
        dmi_scan('0, '0, 2'd0, 0, 0, cap);
        exp_cap = cap_q.pop_front();
        total++;
        if (cap !== exp_cap) $display("FAIL trst_rdata: got %h, expected %h", cap, exp_cap);
        else passed++;
    endtask

`ifdef DTM_DMI_TIMEOUT_EN
    task automatic test_timeout();
        logic [33:0] cap;
        logic [63:0] d;
        bit          ok;
        int unsigned hi;
        dmi_scan(7'h50, 32'h0, 2'd1, 0, 0, cap);
        wait_req(ok);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (dmi_req === 1'b1) hi++;
            @(negedge tck); #1;
        end
        total++;
        if (!ok || hi != 8) $display("FAIL timeout_width: got %0d cycles, expected 8", hi);
        else passed++;
        scan(5'h10, 32, 64'h0001_0000, 0, 0, d);
        total++;
        if (d[31:0] !== 32'h0000_1871) $display("FAIL timeout_sticky: got %h, expected 00001871", d[31:0]);
        else passed++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_dtmcs();
        test_write();
        test_read();
        test_busy();
        test_sticky();
        test_same_edge_capture();
        test_hardreset();
        test_back_to_back();
        test_trst();
`ifdef DTM_DMI_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
